// File: rtl/frame_centroid_pkg.sv
// Shared frame geometry, datapath widths and scan controller states.
package frame_centroid_pkg;

    localparam int unsigned IMG_W   = 200;
    localparam int unsigned IMG_H   = 200;
    localparam int unsigned RD_LAT  = 2;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned COORD_W = 8;
    localparam int unsigned SUM_W   = 24;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PIX_W   = 3;
    localparam int unsigned DRAIN_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DIVX,
        ST_DIVY,
        ST_DONE
    } state_e;

endpackage

// File: rtl/frame_centroid_seq_div.sv
// Sequential restoring divider: one quotient bit per cycle, start/done handshake.
module seq_div
    import frame_centroid_pkg::*;
#(
    parameter int unsigned DVD_W = SUM_W,
    parameter int unsigned DVS_W = CNT_W,
    parameter int unsigned QUO_W = COORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [QUO_W-1:0] quotient
);

    localparam int unsigned STEP_W = $clog2(DVD_W);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DVD_W - 1);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;

    logic [DVS_W:0]   rem_sh;
    logic [DVS_W+1:0] trial;

    // The quotient register starts as the dividend; its MSB feeds the remainder
    // while quotient bits shift in at the LSB.
    always_comb begin
        rem_sh = {rem_q, quo_q[DVD_W-1]};
        trial  = {1'b0, rem_sh} - {2'b00, dvs_q};
        busy_d = busy_q;
        done_d = 1'b0;
        step_d = step_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (busy_q) begin
            if (!trial[DVS_W+1]) begin
                rem_d = trial[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b0};
            end
            if (step_q == LAST_STEP) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                step_d = step_q + 1'b1;
            end
        end else if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            step_d = '0;
            busy_d = 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            step_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            step_q <= step_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q[QUO_W-1:0];

endmodule

// File: rtl/frame_centroid.sv
// Scans the frame RAM, accumulates coordinates of pixels at or above a
// threshold and reports their truncated centroid and count.
module frame_centroid
    import frame_centroid_pkg::*;
#(
    parameter int unsigned IMG_W  = frame_centroid_pkg::IMG_W,
    parameter int unsigned IMG_H  = frame_centroid_pkg::IMG_H,
    parameter int unsigned RD_LAT = frame_centroid_pkg::RD_LAT
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               start,
    input  logic [PIX_W-1:0]   threshold,
    output logic [ADDR_W-1:0]  rdaddr,
    input  logic [PIX_W-1:0]   rddata,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic [CNT_W-1:0]   count
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [COORD_W-1:0] LAST_X     = COORD_W'(IMG_W - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(RD_LAT - 1);

    state_e               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 found_q, found_d;
    logic [COORD_W-1:0]   cx_q, cx_d;
    logic [COORD_W-1:0]   cy_q, cy_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [PIX_W-1:0]     thr_q, thr_d;
    logic [SUM_W-1:0]     sumx_q, sumx_d;
    logic [SUM_W-1:0]     sumy_q, sumy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [COORD_W-1:0]   qx_q, qx_d;
    logic [COORD_W-1:0]   qy_q, qy_d;
    logic [COORD_W-1:0]   dly_x_q [RD_LAT];
    logic [COORD_W-1:0]   dly_x_d [RD_LAT];
    logic [COORD_W-1:0]   dly_y_q [RD_LAT];
    logic [COORD_W-1:0]   dly_y_d [RD_LAT];
    logic [RD_LAT-1:0]    dly_v_q, dly_v_d;

    logic                 hit;
    logic                 div_start;
    logic [SUM_W-1:0]     div_dividend;
    logic                 div_done;
    logic [COORD_W-1:0]   div_quot;

    seq_div #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W),
        .QUO_W (COORD_W)
    ) u_div (
        .clk      (sysclk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (cnt_d),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Delay line carrying x/y/valid so they line up with the returning RAM data.
    always_comb begin
        dly_v_d[0] = (state_q == ST_SCAN);
        dly_x_d[0] = x_q;
        dly_y_d[0] = y_q;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            dly_v_d[i] = dly_v_q[i-1];
            dly_x_d[i] = dly_x_q[i-1];
            dly_y_d[i] = dly_y_q[i-1];
        end
    end

    // Accumulation plus scan/drain/divide sequencing.
    // The last pixel is accumulated on the same edge DRAIN exits, so the exit
    // decision and the x divider start use the next-state sums and count.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        found_d      = found_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        count_d      = count_q;
        addr_d       = addr_q;
        x_d          = x_q;
        y_d          = y_q;
        thr_d        = thr_q;
        sumx_d       = sumx_q;
        sumy_d       = sumy_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        qx_d         = qx_q;
        qy_d         = qy_q;
        div_start    = 1'b0;
        div_dividend = sumy_q;

        hit = dly_v_q[RD_LAT-1] && (rddata >= thr_q);
        if (hit) begin
            sumx_d = sumx_q + SUM_W'(dly_x_q[RD_LAT-1]);
            sumy_d = sumy_q + SUM_W'(dly_y_q[RD_LAT-1]);
            cnt_d  = cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    thr_d   = threshold;
                    sumx_d  = '0;
                    sumy_d  = '0;
                    cnt_d   = '0;
                    qx_d    = '0;
                    qy_d    = '0;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (x_q == LAST_X) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    if (cnt_d == '0) begin
                        qx_d    = '0;
                        qy_d    = '0;
                        state_d = ST_DONE;
                    end else begin
                        div_start    = 1'b1;
                        div_dividend = sumx_d;
                        state_d      = ST_DIVX;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DIVX: begin
                if (div_done) begin
                    qx_d         = div_quot;
                    div_start    = 1'b1;
                    div_dividend = sumy_q;
                    state_d      = ST_DIVY;
                end
            end
            ST_DIVY: begin
                if (div_done) begin
                    qy_d    = div_quot;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                found_d = (cnt_q != '0);
                cx_d    = qx_q;
                cy_d    = qy_q;
                count_d = cnt_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller, datapath and result registers.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            count_q <= '0;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            thr_q   <= '0;
            sumx_q  <= '0;
            sumy_q  <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            dly_x_q <= '{default: '0};
            dly_y_q <= '{default: '0};
            dly_v_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            thr_q   <= thr_d;
            sumx_q  <= sumx_d;
            sumy_q  <= sumy_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            dly_x_q <= dly_x_d;
            dly_y_q <= dly_y_d;
            dly_v_q <= dly_v_d;
        end
    end

    assign rdaddr = addr_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign cx     = cx_q;
    assign cy     = cy_q;
    assign count  = count_q;

endmodule

// File: tb/tb_frame_centroid.sv
// Directed bench: six centroid units scan six frame-RAM images in parallel,
// one of them reset mid-scan and restarted.
module tb_frame_centroid;

    localparam int NI = 6;
    localparam int unsigned BOUND = 200 * 200 + 2 + 60;

    logic        sysclk = 1'b0;
    logic        rst       [NI];
    logic        start     [NI];
    logic [2:0]  threshold [NI];
    logic [15:0] rdaddr    [NI];
    logic [2:0]  rddata    [NI];
    logic        busy      [NI];
    logic        done      [NI];
    logic        found     [NI];
    logic [7:0]  cx        [NI];
    logic [7:0]  cy        [NI];
    logic [15:0] count     [NI];

    logic [2:0]  pipe0 [NI] = '{default: '0};
    logic [2:0]  pipe1 [NI] = '{default: '0};

    int unsigned cyc = 0;
    int unsigned cyc_s = 0;
    int unsigned cyc_s5 = 0;
    int unsigned done_cnt [NI] = '{default: 0};
    int unsigned done_cyc [NI] = '{default: 0};
    logic        cap_found [NI];
    logic [7:0]  cap_cx    [NI];
    logic [7:0]  cap_cy    [NI];
    logic [15:0] cap_count [NI];

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Hand-computed expectations per unit.
    logic [2:0]  thr_v   [NI] = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd0, 3'd4};
    logic        exp_fnd [NI] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0]  exp_cx  [NI] = '{8'd0, 8'd10, 8'd100, 8'd99, 8'd99, 8'd10};
    logic [7:0]  exp_cy  [NI] = '{8'd0, 8'd20, 8'd50, 8'd99, 8'd99, 8'd20};
    logic [15:0] exp_cnt [NI] = '{16'd0, 16'd1, 16'd4, 16'd2, 16'd40000, 16'd1};

    always #5 sysclk = ~sysclk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            frame_centroid #(
                .IMG_W  (200),
                .IMG_H  (200),
                .RD_LAT (2)
            ) u_dut (
                .sysclk    (sysclk),
                .rst       (rst[g]),
                .start     (start[g]),
                .threshold (threshold[g]),
                .rdaddr    (rdaddr[g]),
                .rddata    (rddata[g]),
                .busy      (busy[g]),
                .done      (done[g]),
                .found     (found[g]),
                .cx        (cx[g]),
                .cy        (cy[g]),
                .count     (count[g])
            );
            assign rddata[g] = pipe1[g];
        end
    endgenerate

    // Frame image held by each unit's RAM.
    function automatic logic [2:0] pix(input int inst, input logic [15:0] a);
        int unsigned x;
        int unsigned y;
        x = 32'(a) % 200;
        y = 32'(a) / 200;
        case (inst)
            1, 5:    return (a == 16'd4010) ? 3'd7 : 3'd0;
            2:       return (x >= 100 && x <= 101 && y >= 50 && y <= 51) ? 3'd5 : 3'd0;
            3:       return (a == 16'd0 || a == 16'd39999) ? 3'd6 : 3'd0;
            4:       return a[2:0];
            default: return 3'd0;
        endcase
    endfunction

    // Two-cycle read latency RAM models.
    always @(posedge sysclk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            pipe0[i] <= pix(i, rdaddr[i]);
            pipe1[i] <= pipe0[i];
        end
    end

    // Capture results on each done pulse.
    always @(negedge sysclk) begin
        for (int i = 0; i < NI; i++) begin
            if (done[i] === 1'b1) begin
                done_cnt[i]  = done_cnt[i] + 1;
                done_cyc[i]  = cyc;
                cap_found[i] = found[i];
                cap_cx[i]    = cx[i];
                cap_cy[i]    = cy[i];
                cap_count[i] = count[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NI; i++)
            if (done_cnt[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i]       = 1'b1;
            start[i]     = 1'b0;
            threshold[i] = 3'd0;
        end
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_busy[%0d]", i),   32'(busy[i]),   0);
            chk($sformatf("rst_done[%0d]", i),   32'(done[i]),   0);
            chk($sformatf("rst_found[%0d]", i),  32'(found[i]),  0);
            chk($sformatf("rst_cx[%0d]", i),     32'(cx[i]),     0);
            chk($sformatf("rst_cy[%0d]", i),     32'(cy[i]),     0);
            chk($sformatf("rst_count[%0d]", i),  32'(count[i]),  0);
            chk($sformatf("rst_rdaddr[%0d]", i), 32'(rdaddr[i]), 0);
        end
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        repeat (5) @(negedge sysclk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("no_done_idle[%0d]", i), done_cnt[i], 0);

        // Launch every unit together.
        for (int i = 0; i < NI; i++) begin
            threshold[i] = thr_v[i];
            start[i]     = 1'b1;
        end
        @(negedge sysclk);
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
        cyc_s = cyc;
        for (int i = 0; i < NI; i++)
            chk($sformatf("busy_after_start[%0d]", i), 32'(busy[i]), 1);
        chk("rdaddr_scan0", 32'(rdaddr[0]), 0);

        // Reset unit 5 at scan cycle 1000.
        repeat (1000) @(negedge sysclk);
        chk("rdaddr_scan1000_u0", 32'(rdaddr[0]), 1000);
        chk("rdaddr_scan1000_u5", 32'(rdaddr[5]), 1000);
        rst[5] = 1'b1;
        @(negedge sysclk);
        chk("midrst_busy",   32'(busy[5]),   0);
        chk("midrst_done",   32'(done[5]),   0);
        chk("midrst_found",  32'(found[5]),  0);
        chk("midrst_cx",     32'(cx[5]),     0);
        chk("midrst_cy",     32'(cy[5]),     0);
        chk("midrst_count",  32'(count[5]),  0);
        chk("midrst_rdaddr", 32'(rdaddr[5]), 0);
        chk("rdaddr_scan1001_u0", 32'(rdaddr[0]), 1001);
        rst[5] = 1'b0;
        repeat (10) @(negedge sysclk);
        chk("midrst_no_done", done_cnt[5], 0);
        chk("midrst_idle",    32'(busy[5]), 0);

        // Restart unit 5, then poke starts while units 1 and 5 are busy.
        threshold[5] = 3'd4;
        start[5]     = 1'b1;
        @(negedge sysclk);
        start[5] = 1'b0;
        cyc_s5   = cyc;
        chk("restart_busy", 32'(busy[5]), 1);
        repeat (500) @(negedge sysclk);
        threshold[1] = 3'd0;
        threshold[5] = 3'd0;
        start[1]     = 1'b1;
        start[5]     = 1'b1;
        @(negedge sysclk);
        start[1] = 1'b0;
        start[5] = 1'b0;

        begin
            int unsigned t;
            t = 0;
            while (!all_done() && t < 45000) begin
                @(negedge sysclk);
                t++;
            end
        end
        repeat (50) @(negedge sysclk);

        for (int i = 0; i < NI; i++) begin
            int unsigned lat;
            lat = done_cyc[i] - ((i == 5) ? cyc_s5 : cyc_s);
            chk($sformatf("done_pulses[%0d]", i), done_cnt[i], 1);
            chk($sformatf("latency_ok[%0d]", i), 32'(lat <= BOUND && done_cnt[i] != 0), 1);
            chk($sformatf("found[%0d]", i), 32'(cap_found[i]), 32'(exp_fnd[i]));
            chk($sformatf("cx[%0d]", i),    32'(cap_cx[i]),    32'(exp_cx[i]));
            chk($sformatf("cy[%0d]", i),    32'(cap_cy[i]),    32'(exp_cy[i]));
            chk($sformatf("count[%0d]", i), 32'(cap_count[i]), 32'(exp_cnt[i]));
            chk($sformatf("hold_cx[%0d]", i),    32'(cx[i]),    32'(exp_cx[i]));
            chk($sformatf("hold_count[%0d]", i), 32'(count[i]), 32'(exp_cnt[i]));
            chk($sformatf("idle_busy[%0d]", i),  32'(busy[i]),  0);
            chk($sformatf("idle_rdaddr[%0d]", i), 32'(rdaddr[i]), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_centroid.md
FRAME_CENTROID -- requirements
Module: frame_centroid

Interface
REQ-001 Parameters SHALL be: IMG_W, 200, window width in pixels; IMG_H, 200, window height in lines; RD_LAT, 2, frame-RAM read latency in cycles from rdaddr to rddata.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 sysclk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle request to scan the frame buffer.
REQ-006 threshold  input  3  minimum pixel value counted as target; sampled at accepted start.
REQ-007 rdaddr  output  16  frame-RAM read address, row-major, addr = y*IMG_W + x.
REQ-008 rddata  input  3  frame-RAM read data, valid RD_LAT cycles after rdaddr.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse when results are updated.
REQ-011 found  output  1  at least one pixel qualified in last scan.
REQ-012 cx  output  8  centroid x of qualifying pixels, truncated.
REQ-013 cy  output  8  centroid y of qualifying pixels, truncated.
REQ-014 count  output  16  number of qualifying pixels in last scan.

Function
REQ-015 States SHALL be IDLE, SCAN, DRAIN, DIVX, DIVY, DONE.
REQ-016 IDLE: start=1 SHALL latch threshold, clear accumulators, set busy, go to SCAN next cycle.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 SCAN: rdaddr SHALL step 0..IMG_W*IMG_H-1, one address per cycle, with x/y counters advancing alongside (x wraps IMG_W-1 to 0 and y increments).
REQ-019 x, y and a valid bit SHALL be delayed RD_LAT cycles so they align with rddata.
REQ-020 Aligned pixel SHALL qualify iff rddata >= threshold (unsigned); on qualify: sumx += x, sumy += y, cnt += 1.
REQ-021 sumx/sumy SHALL be 24-bit unsigned and cnt 16-bit; no overflow is possible at 200x200.
REQ-022 After the last address, DRAIN SHALL wait RD_LAT cycles for in-flight data, then go to DIVX.
REQ-023 cnt=0 SHALL skip DIVX/DIVY: found=0, cx=0, cy=0, count=0.
REQ-024 DIVX/DIVY SHALL compute sumx/cnt and sumy/cnt by sequential restoring division, one quotient bit per cycle (24 cycles each), quotient truncated to 8 bits.
REQ-025 DONE SHALL load found/cx/cy/count together, pulse done for exactly one cycle, drop busy, return to IDLE.
REQ-026 cx/cy/count/found SHALL hold stable between done pulses.
REQ-027 rdaddr SHALL hold 0 outside SCAN.
REQ-028 done SHALL occur no later than IMG_W*IMG_H + RD_LAT + 60 cycles after accepted start.

Reset
REQ-029 rst SHALL force state IDLE, busy=0, done=0, found=0, cx=0, cy=0, count=0, rdaddr=0, and clear accumulators and the delay line, at any time including mid-SCAN or mid-division.
REQ-030 After rst deasserts, no done SHALL appear until a new start is accepted.

Structure
REQ-031 Shared package SHALL hold IMG_W, IMG_H, address/coordinate/sum/count widths, and the state enumeration.
REQ-032 The divider SHALL be sub-module seq_div (24-bit dividend, 16-bit divisor, start/done handshake), instantiated once and reused for x then y.

Verification
REQ-033 RAM all zeros, threshold=1, start -> done once, found=0, cx=0, cy=0, count=0.
REQ-034 Single value 7 at x=10,y=20 (addr 4010), threshold=4 -> found=1, cx=10, cy=20, count=1.
REQ-035 Value 5 at x=100..101, y=50..51, rest 0, threshold=5 -> count=4, cx=100, cy=50 (truncation).
REQ-036 Value 6 at (0,0) and (199,199), threshold=6 -> count=2, cx=99, cy=99; threshold=0 on any RAM -> count=40000, cx=99, cy=99.
REQ-037 rst asserted at cycle 1000 of SCAN -> all outputs zero next cycle, no done; then start with REQ-034 RAM -> correct result; a start pulsed during that busy period is ignored (exactly one done).
